counter_sequencer: RTL
======================

# counter_sequencer

Synchronous controller that sequences a WIDTH-bit up-counter: captures a terminal count on a start command, counts 0..term, pulses done, and either stops (one-shot) or reloads (auto-reload). Supports pause/resume and abort. It sits in the counter datapath as the control layer, giving upstream logic a start/stop/pause command interface instead of direct counter reset control.

## Interface
- WIDTH, 4, counter and terminal-count width
- PERIOD_W, 8, width of completed-period counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  command: begin counting; sampled only in IDLE or DONE
- stop  in  1  command: abort to IDLE, clear count
- pause  in  1  level: freeze count while high (RUN/HOLD only)
- mode  in  1  0 = one-shot, 1 = auto-reload; captured with start
- term  in  WIDTH  terminal count; captured with start
- q  out  WIDTH  current count (registered)
- busy  out  1  high in RUN or HOLD
- done  out  1  one-cycle pulse when count reaches captured term
- periods  out  PERIOD_W  completed periods since last start, saturating

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Command priority per edge: rst > stop > start > pause.
- IDLE: q=0. start → RUN; term_r←term, mode_r←mode, q←0, periods←0.
- RUN, pause=0: if q==term_r → done←1, periods←sat(periods+1); mode_r=1 → q←0, stay RUN; mode_r=0 → DONE, q holds term_r. Else q←q+1.
- RUN, pause=1 → HOLD, q unchanged. HOLD, pause=1 → stay; pause=0 → RUN, counting resumes next edge.
- stop in RUN/HOLD/DONE → IDLE, q←0, no done pulse, periods held.
- DONE: q holds term_r, busy=0. start → RUN with fresh capture (same as from IDLE).
- start in RUN/HOLD ignored; term/mode changes after capture ignored.
- term=0: q stays 0; done fires every cycle in auto-reload, once in one-shot.
- term = 2^WIDTH−1: counts full range, never overflows (compare precedes increment).
- periods saturates at 2^PERIOD_W−1; no wrap.

## Timing
- Reset values: state=IDLE, q=0, busy=0, done=0, periods=0, term_r=0, mode_r=0.
- Reset mid-operation: same values on the next edge; no done pulse generated.
- All outputs registered; no combinational input→output paths.
- start sampled at edge E0 → busy=1, q=0 after E0; q=k after E0+k.
- done high for exactly the cycle after edge E0+term+1 (start-to-done latency term+2 edges with no pause).
- Auto-reload period = term+1 cycles; done pulses spaced term+1 cycles apart.
- Each HOLD cycle adds one cycle of latency; pause asserted on the edge where q==term_r defers done.
- done and periods update on the same edge.

## Structure
- Shared package counter_pkg: state enum (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3) and default PERIOD_W.
- One sub-module: sync_up_counter (WIDTH param; clk, rst, clr, en; q). The sequencer drives clr/en; the terminal compare, FSM and periods live in counter_sequencer.

## Test plan
- Reset held 2 cycles then released → q=0, busy=0, done=0, periods=0; rst pulse mid-RUN at q=5 → all reset values next edge, no done.
- One-shot, term=3, start 1 cycle → q=0,1,2,3; done single pulse 5 edges after start; state DONE, q holds 3, busy=0, periods=1.
- Auto-reload, term=2, run 9 cycles → q sequence 0,1,2,0,1,2,…; done every 3rd cycle; periods=3.
- term=6, pause high 3 cycles at q=4 → q holds 4 for 3 cycles, busy stays 1; done delayed by exactly 3 cycles.
- stop at q=2 with start same cycle → IDLE, q=0, no done; start during RUN with term=1 → ignored, original term_r kept.
- Edge values: term=0 auto-reload → done every cycle; term=15 one-shot → q reaches 15 without wrap, done once; PERIOD_W=2 with 5 periods → periods=3.

Source files
------------

// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter sequencer slice: the sequencer state
// encoding and the default width of the completed-period counter.
// No ports (package).
// ----------------------------------------------------------------------------
package counter_pkg;

   // Default width of the saturating completed-period counter.
   localparam int unsigned PERIOD_W_DEFAULT = 8;

   // Sequencer states; encoding is fixed so software/debug views stay stable.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage : counter_pkg

// File: rtl/sync_up_counter.sv
// ----------------------------------------------------------------------------
// sync_up_counter
// Plain WIDTH-bit synchronous up-counter. Clear has priority over enable;
// wrap-around is never exercised because the sequencer stops incrementing
// at the terminal count.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset, clears the count
//   i_clr  - synchronous clear to zero
//   i_en   - increment enable
//   o_q    - current count (registered)
// ----------------------------------------------------------------------------
module sync_up_counter #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_q
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_q;

   // Count register: reset, then clear, then increment.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= r_q + ONE;
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule : sync_up_counter

// File: rtl/counter_sequencer.sv
// ----------------------------------------------------------------------------
// counter_sequencer
// Control layer over a WIDTH-bit up-counter. A start command captures the
// terminal count and mode, the counter runs 0..term, done pulses for one
// cycle at the terminal count, and the sequencer then either stops holding
// term (one-shot) or reloads to 0 (auto-reload). Pause freezes the count,
// stop aborts to idle with the count cleared.
// Ports:
//   i_clk      - clock, rising edge
//   i_rst      - synchronous active-high reset
//   i_start    - begin counting (honoured only when idle or done)
//   i_stop     - abort to idle, clear count (wins over start)
//   i_pause    - level; freezes the count while running
//   i_mode     - 0 one-shot, 1 auto-reload; captured with start
//   i_term     - terminal count; captured with start
//   o_q        - current count (registered)
//   o_busy     - high while running or paused
//   o_done     - one-cycle pulse when the count reaches the captured term
//   o_periods  - completed periods since the last start, saturating
// ----------------------------------------------------------------------------
module counter_sequencer
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PERIOD_W = PERIOD_W_DEFAULT
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_pause,
   input  logic                i_mode,
   input  logic [WIDTH-1:0]    i_term,
   output logic [WIDTH-1:0]    o_q,
   output logic                o_busy,
   output logic                o_done,
   output logic [PERIOD_W-1:0] o_periods
);

   localparam logic [PERIOD_W-1:0] PERIODS_MAX = {PERIOD_W{1'b1}};
   localparam logic [PERIOD_W-1:0] PERIODS_ONE = PERIOD_W'(1);

   state_t              r_state;
   logic [WIDTH-1:0]    r_term;
   logic                r_mode;
   logic                r_done;
   logic                r_busy;
   logic [PERIOD_W-1:0] r_periods;

   state_t              w_state_nxt;
   logic [WIDTH-1:0]    w_term_nxt;
   logic                w_mode_nxt;
   logic                w_done_nxt;
   logic [PERIOD_W-1:0] w_periods_nxt;
   logic [PERIOD_W-1:0] w_periods_inc;
   logic                w_clr;
   logic                w_en;
   logic                w_at_term;
   logic [WIDTH-1:0]    w_cnt_q;

   sync_up_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_clr),
      .i_en  (w_en),
      .o_q   (w_cnt_q)
   );

   // Compare happens before any increment, so term = all-ones never wraps.
   assign w_at_term     = (w_cnt_q == r_term);
   assign w_periods_inc = (r_periods == PERIODS_MAX) ? r_periods
                                                     : (r_periods + PERIODS_ONE);

   // Next-state, counter control and capture decode (stop > start > pause).
   always_comb begin
      w_state_nxt   = r_state;
      w_term_nxt    = r_term;
      w_mode_nxt    = r_mode;
      w_done_nxt    = 1'b0;
      w_periods_nxt = r_periods;
      w_clr         = 1'b0;
      w_en          = 1'b0;

      if (i_stop) begin
         // Abort: count cleared, periods and captured values kept.
         w_state_nxt = ST_IDLE;
         w_clr       = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  w_state_nxt   = ST_RUN;
                  w_term_nxt    = i_term;
                  w_mode_nxt    = i_mode;
                  w_periods_nxt = '0;
                  w_clr         = 1'b1;
               end else begin
                  w_state_nxt = r_state;
               end
            end
            // HOLD with pause released behaves like an unpaused RUN edge, so
            // each cycle spent in HOLD costs exactly one cycle of latency.
            ST_RUN, ST_HOLD: begin
               if (i_pause) begin
                  w_state_nxt = ST_HOLD;
               end else if (w_at_term) begin
                  w_done_nxt    = 1'b1;
                  w_periods_nxt = w_periods_inc;
                  if (r_mode) begin
                     w_state_nxt = ST_RUN;
                     w_clr       = 1'b1;
                  end else begin
                     w_state_nxt = ST_DONE;
                  end
               end else begin
                  w_state_nxt = ST_RUN;
                  w_en        = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_clr       = 1'b1;
            end
         endcase
      end
   end

   // Sequencer state and registered status outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_term    <= '0;
         r_mode    <= 1'b0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_periods <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_term    <= w_term_nxt;
         r_mode    <= w_mode_nxt;
         r_done    <= w_done_nxt;
         r_busy    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
         r_periods <= w_periods_nxt;
      end
   end

   assign o_q       = w_cnt_q;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_periods = r_periods;

endmodule : counter_sequencer
